alu_ctrl: RTL and testbench

ALU_CTRL -- requirements
Module: alu_ctrl

---
 rtl/alu_ctrl.sv | 124 ++++++++++++
 tb/tb_alu_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl.sv
// Request/response sequencer for a combinational 8-bit ALU.
// It issues one operation, waits SETTLE cycles, then captures the result and flags.
module alu_ctrl #(
  parameter int SETTLE = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic [3:0] REQ_OP,
  input  logic [7:0] REQ_A,
  input  logic [7:0] REQ_B,
  output logic [7:0] ALU_A,
  output logic [7:0] ALU_B,
  output logic [3:0] ALU_SSEL,
  input  logic [7:0] ALU_F,
  input  logic       ALU_Z,
  input  logic       ALU_S,
  input  logic       ALU_C,
  input  logic       ALU_V,
  output logic       RSP_VALID,
  input  logic       RSP_READY,
  output logic [7:0] RSP_F,
  output logic [3:0] RSP_FLAGS,
  output logic       RSP_ERR,
  output logic [3:0] STATUS
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, RESP} state_t;

  localparam logic [3:0] LP_CNT_INIT = 4'(SETTLE - 1);

  state_t     r_state, w_next;
  logic [3:0] r_op;
  logic [7:0] r_a, r_b;
  logic [3:0] r_cnt;
  logic [7:0] r_rsp_f;
  logic [3:0] r_rsp_flags;
  logic       r_rsp_err;
  logic [3:0] r_status;

  logic w_accept, w_legal, w_issue, w_cnt_done;

  function automatic logic legal_op(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0101, 4'b0110,
      4'b0111, 4'b1000, 4'b1010, 4'b1100, 4'b1110: legal_op = 1'b1;
      default:                                     legal_op = 1'b0;
    endcase
  endfunction

  assign w_accept   = REQ_VALID && (r_state == IDLE);
  assign w_legal    = legal_op(REQ_OP);
  assign w_issue    = (r_state == DRIVE) || (r_state == SAMPLE);
  assign w_cnt_done = (r_cnt == 4'd0);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_legal ? DRIVE : RESP;
      DRIVE:   w_next = SAMPLE;
      SAMPLE:  if (w_cnt_done) w_next = RESP;
      RESP:    if (RSP_READY) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_op        <= 4'd0;
      r_a         <= 8'd0;
      r_b         <= 8'd0;
      r_cnt       <= 4'd0;
      r_rsp_f     <= 8'd0;
      r_rsp_flags <= 4'd0;
      r_rsp_err   <= 1'b0;
      r_status    <= 4'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_legal) begin
              r_op <= REQ_OP;
              r_a  <= REQ_A;
              r_b  <= REQ_B;
            end else begin
              // Rejected op answers immediately; the ALU never sees it.
              r_rsp_f     <= 8'd0;
              r_rsp_flags <= 4'd0;
              r_rsp_err   <= 1'b1;
            end
          end
        end
        DRIVE: r_cnt <= LP_CNT_INIT;
        SAMPLE: begin
          if (w_cnt_done) begin
            r_rsp_f     <= ALU_F;
            r_rsp_flags <= {ALU_Z, ALU_S, ALU_C, ALU_V};
            r_rsp_err   <= 1'b0;
            r_status    <= {ALU_Z, ALU_S, ALU_C, ALU_V};
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // ALU inputs are forced to zero whenever no operation is in flight.
  assign ALU_A     = w_issue ? r_a  : 8'd0;
  assign ALU_B     = w_issue ? r_b  : 8'd0;
  assign ALU_SSEL  = w_issue ? r_op : 4'd0;

  assign REQ_READY = (r_state == IDLE);
  assign RSP_VALID = (r_state == RESP);
  assign RSP_F     = r_rsp_f;
  assign RSP_FLAGS = r_rsp_flags;
  assign RSP_ERR   = r_rsp_err;
  assign STATUS    = r_status;

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl: SETTLE=1 and SETTLE=3 instances, each driving a behavioural ALU.
module tb_alu_ctrl;
  logic       CLK = 1'b0;
  logic       RST;
  logic       v1, v3, rsp_ready;
  logic [3:0] op;
  logic [7:0] a, b;

  logic       rr1, rv1, err1, rr3, rv3, err3;
  logic [7:0] aa1, ab1, f1, aa3, ab3, f3;
  logic [3:0] sel1, fl1, st1, sel3, fl3, st3;
  logic [11:0] m1, m3;

  int n_tot = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  // Reference ALU: returns {F, Z, S, C, V}; C on subtract/decrement is borrow.
  function automatic logic [11:0] alu(input logic [3:0] s, input logic [7:0] x, input logic [7:0] y);
    logic [8:0] t;
    logic [7:0] f;
    logic       c, v;
    t = 9'd0; f = 8'd0; c = 1'b0; v = 1'b0;
    case (s)
      4'h0, 4'h7: f = x;
      4'h1: begin t = {1'b0, x} + 9'd1; f = t[7:0]; c = t[8]; v = (x == 8'h7F); end
      4'h2: begin t = {1'b0, x} + {1'b0, y}; f = t[7:0]; c = t[8];
                  v = (x[7] == y[7]) && (f[7] != x[7]); end
      4'h5: begin f = x - y; c = (x < y); v = (x[7] != y[7]) && (f[7] != x[7]); end
      4'h6: begin f = x - 8'd1; c = (x == 8'd0); v = (x == 8'h80); end
      4'h8: f = x & y;
      4'hA: f = x | y;
      4'hC: f = x ^ y;
      4'hE: f = ~x;
      default: f = 8'd0;
    endcase
    return {f, (f == 8'd0), f[7], c, v};
  endfunction

  assign m1 = alu(sel1, aa1, ab1);
  assign m3 = alu(sel3, aa3, ab3);

  alu_ctrl #(.SETTLE(1)) u1 (
    .CLK(CLK), .RST(RST), .REQ_VALID(v1), .REQ_READY(rr1), .REQ_OP(op), .REQ_A(a), .REQ_B(b),
    .ALU_A(aa1), .ALU_B(ab1), .ALU_SSEL(sel1), .ALU_F(m1[11:4]),
    .ALU_Z(m1[3]), .ALU_S(m1[2]), .ALU_C(m1[1]), .ALU_V(m1[0]),
    .RSP_VALID(rv1), .RSP_READY(rsp_ready), .RSP_F(f1), .RSP_FLAGS(fl1), .RSP_ERR(err1), .STATUS(st1));

  alu_ctrl #(.SETTLE(3)) u3 (
    .CLK(CLK), .RST(RST), .REQ_VALID(v3), .REQ_READY(rr3), .REQ_OP(op), .REQ_A(a), .REQ_B(b),
    .ALU_A(aa3), .ALU_B(ab3), .ALU_SSEL(sel3), .ALU_F(m3[11:4]),
    .ALU_Z(m3[3]), .ALU_S(m3[2]), .ALU_C(m3[1]), .ALU_V(m3[0]),
    .RSP_VALID(rv3), .RSP_READY(rsp_ready), .RSP_F(f3), .RSP_FLAGS(fl3), .RSP_ERR(err3), .STATUS(st3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    op = o; a = x; b = y; v1 = 1'b1;
    tick();
    v1 = 1'b0;
  endtask

  initial begin
    RST = 1'b1; v1 = 1'b0; v3 = 1'b0; rsp_ready = 1'b1; op = 4'd0; a = 8'd0; b = 8'd0;
    tick(); tick();
    RST = 1'b0;
    // reset state
    chk("rst_rdy", rr1, 1); chk("rst_rv", rv1, 0); chk("rst_f", f1, 0);
    chk("rst_fl", fl1, 0); chk("rst_err", err1, 0); chk("rst_st", st1, 0);
    chk("rst_alu", {aa1, ab1, sel1}, 0);

    // add 7F+01, response two cycles after accept
    issue(4'b0010, 8'h7F, 8'h01);
    chk("add_drv_rdy", rr1, 0); chk("add_drv_rv", rv1, 0);
    chk("add_drv_alu", {aa1, ab1, sel1}, {8'h7F, 8'h01, 4'h2});
    tick();
    chk("add_smp_rv", rv1, 0); chk("add_smp_sel", sel1, 4'h2);
    tick();
    chk("add_rv", rv1, 1); chk("add_f", f1, 8'h80); chk("add_fl", fl1, 4'b0101);
    chk("add_err", err1, 0); chk("add_st", st1, 4'b0101); chk("add_rsp_sel", sel1, 0);
    tick();
    chk("add_idle_rdy", rr1, 1); chk("add_idle_rv", rv1, 0); chk("add_hold_f", f1, 8'h80);

    // subtract equal operands -> zero
    issue(4'b0101, 8'h05, 8'h05);
    chk("sub_drv_sel", sel1, 4'b0101);
    tick();
    chk("sub_smp_sel", sel1, 4'b0101);
    tick();
    chk("sub_f", f1, 8'h00); chk("sub_fl", fl1, 4'b1000); chk("sub_err", err1, 0);
    chk("sub_st", st1, 4'b1000); chk("sub_rsp_sel", sel1, 0);
    tick();
    chk("sub_idle_sel", sel1, 0);

    // illegal code: immediate error response, STATUS untouched
    issue(4'b0011, 8'hFF, 8'h00);
    chk("ill_rv", rv1, 1); chk("ill_f", f1, 0); chk("ill_fl", fl1, 0); chk("ill_err", err1, 1);
    chk("ill_st", st1, 4'b1000); chk("ill_sel", sel1, 0);
    tick();
    chk("ill_idle", rr1, 1);

    // XOR with consumer stalling 5 cycles; new requests ignored meanwhile
    rsp_ready = 1'b0;
    issue(4'b1100, 8'hF0, 8'h0F);
    tick(); tick();
    op = 4'b0010; a = 8'h01; b = 8'h01; v1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("xor_hold_rv", rv1, 1); chk("xor_hold_f", f1, 8'hFF);
      chk("xor_hold_fl", fl1, 4'b0100); chk("xor_hold_rdy", rr1, 0);
      tick();
    end
    v1 = 1'b0; rsp_ready = 1'b1;
    tick();
    chk("xor_rel_rdy", rr1, 1); chk("xor_rel_rv", rv1, 0);
    chk("xor_rel_f", f1, 8'hFF); chk("xor_st", st1, 4'b0100);
    tick();
    chk("xor_no_queue", {rr1, rv1}, 2'b10);

    // reset during SAMPLE discards the add
    issue(4'b0010, 8'h10, 8'h20);
    tick();
    chk("rst_mid_sel", sel1, 4'h2);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rst_mid_rdy", rr1, 1); chk("rst_mid_rv", rv1, 0); chk("rst_mid_st", st1, 0);
    chk("rst_mid_f", f1, 0);
    tick();
    chk("rst_mid_norsp", rv1, 0);

    // SETTLE=3: response four cycles after accept
    op = 4'b1000; a = 8'hAA; b = 8'h0F; v3 = 1'b1;
    tick();
    v3 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("s3_wait_rv", rv3, 0);
      chk("s3_wait_sel", sel3, 4'b1000);
      tick();
    end
    chk("s3_rv", rv3, 1); chk("s3_f", f3, 8'h0A); chk("s3_fl", fl3, 4'b0000);
    chk("s3_err", err3, 0); chk("u1_quiet", rv1, 0);
    tick();
    chk("s3_idle", rr3, 1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
